seg_mem_responder: RTL and testbench

SEG_MEM_RESPONDER -- requirements
Module: seg_mem_responder

---
 rtl/seg_mem_responder_if.sv | 35 +++
 rtl/seg_mem_responder.sv | 93 +++++++++
 tb/tb_seg_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_mem_responder_if.sv
// CPU-side and host-side signal bundle for seg_mem_responder.
// The master modport drives requests; the slave modport is the responder.
interface seg_mem_responder_if #(
    parameter int SegmentWidth = 2,
    parameter int OffsetWidth  = 8,
    parameter int nSegments    = 1 << SegmentWidth,
    parameter int DAW          = SegmentWidth + OffsetWidth,
    parameter int DWW          = 36
);
    logic [nSegments-1:0][OffsetWidth-1:0] readAddresses;
    logic [nSegments-1:0][DWW-1:0]         readDatas;
    logic [OffsetWidth-1:0]                writeAddress;
    logic [DWW-1:0]                        writeData;
    logic [nSegments-1:0]                  writeEnables;

    logic                                  hostReq;
    logic                                  hostWe;
    logic [DAW-1:0]                        hostAddr;
    logic [DWW-1:0]                        hostWData;
    logic                                  hostAck;
    logic [DWW-1:0]                        hostRData;
    logic                                  hostBusy;

    modport master (
        output readAddresses, writeAddress, writeData, writeEnables,
        output hostReq, hostWe, hostAddr, hostWData,
        input  readDatas, hostAck, hostRData, hostBusy
    );

    modport slave (
        input  readAddresses, writeAddress, writeData, writeEnables,
        input  hostReq, hostWe, hostAddr, hostWData,
        output readDatas, hostAck, hostRData, hostBusy
    );
endinterface

// File: rtl/seg_mem_responder.sv
// Segmented dual-port word memory: CPU reads (1-cycle registered) and writes, plus a host port.
// Host access latency 2 (write) / 3 (read) cycles; stalls in PEND while the CPU writes its segment.
module seg_mem_responder #(
    parameter int SegmentWidth = 2,
    parameter int OffsetWidth  = 8,
    parameter int nSegments    = 1 << SegmentWidth,
    parameter int DAW          = SegmentWidth + OffsetWidth,
    parameter int DWW          = 36
) (
    input  logic              clk,
    input  logic              rst,
    seg_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, RDWAIT, ACK} state_t;

    state_t r_state, w_next;

    logic                          r_we;
    logic [SegmentWidth-1:0]       r_seg;
    logic [OffsetWidth-1:0]        r_off;
    logic [DWW-1:0]                r_wdata;
    logic [DWW-1:0]                r_p1_rdata;
    logic [DWW-1:0]                r_hrdata;
    logic [nSegments-1:0][DWW-1:0] r_rdata;
    logic [DWW-1:0]                r_mem [nSegments][2**OffsetWidth];

    logic w_blocked;
    logic w_issue;

    assign w_blocked = bus.writeEnables[r_seg];
    assign w_issue   = (r_state == PEND) && !w_blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.hostReq) w_next = PEND;
            PEND:    if (!w_blocked) w_next = r_we ? ACK : RDWAIT;
            RDWAIT:  w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_seg      <= '0;
            r_off      <= '0;
            r_wdata    <= '0;
            r_p1_rdata <= '0;
            r_hrdata   <= '0;
        end else begin
            if (r_state == IDLE && bus.hostReq) begin
                r_we    <= bus.hostWe;
                r_seg   <= bus.hostAddr[DAW-1 -: SegmentWidth];
                r_off   <= bus.hostAddr[OffsetWidth-1:0];
                r_wdata <= bus.hostWData;
            end
            if (w_issue && !r_we) r_p1_rdata <= r_mem[r_seg][r_off];
            if (r_state == RDWAIT) r_hrdata <= r_p1_rdata;
        end
    end

    // Port 1 is shared: a CPU write to the segment always wins over the host.
    always_ff @(posedge clk) begin
        for (int s = 0; s < nSegments; s++) begin
            if (bus.writeEnables[s])
                r_mem[s][bus.writeAddress] <= bus.writeData;
            else if (w_issue && r_we && (r_seg == SegmentWidth'(s)))
                r_mem[s][r_off] <= r_wdata;
        end
    end

    // Port 0 sees the pre-write word when port 1 writes the same address in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            for (int s = 0; s < nSegments; s++)
                r_rdata[s] <= r_mem[s][bus.readAddresses[s]];
        end
    end

    assign bus.readDatas = r_rdata;
    assign bus.hostRData = r_hrdata;
    assign bus.hostAck   = (r_state == ACK);
    assign bus.hostBusy  = (r_state != IDLE);
endmodule

// File: tb/tb_seg_mem_responder.sv
// Bench for seg_mem_responder: directed vector table, corner sequences, randomized traffic vs a reference model.
module tb_seg_mem_responder;
    localparam int SW  = 2;
    localparam int OW  = 8;
    localparam int NS  = 4;
    localparam int DAW = 10;
    localparam int DW  = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_mem_responder_if #(.SegmentWidth(SW), .OffsetWidth(OW), .nSegments(NS), .DAW(DAW), .DWW(DW)) bus();

    seg_mem_responder #(.SegmentWidth(SW), .OffsetWidth(OW), .nSegments(NS), .DAW(DAW), .DWW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mm [NS][256];
    logic [DW-1:0] exp_hr;

    typedef struct {
        int            seg;
        int            off;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.readAddresses = '0;
        bus.writeAddress  = '0;
        bus.writeData     = '0;
        bus.writeEnables  = '0;
        bus.hostReq       = 1'b0;
        bus.hostWe        = 1'b0;
        bus.hostAddr      = '0;
        bus.hostWData     = '0;
    endtask

    task automatic cpu_wr(input int s, input int o, input logic [DW-1:0] d);
        bus.writeEnables = NS'(1 << s);
        bus.writeAddress = OW'(o);
        bus.writeData    = d;
        mm[s][o]         = d;
    endtask

    task automatic host_req(input logic we, input int s, input int o, input logic [DW-1:0] d);
        bus.hostReq   = 1'b1;
        bus.hostWe    = we;
        bus.hostAddr  = {SW'(s), OW'(o)};
        bus.hostWData = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        vec_t          vt [6];
        logic [DW-1:0] exp_rd [NS];
        bit            rd_valid;
        logic          exp_ack, exp_busy;
        bit            hm_wait, hm_we;
        int            hm_seg, hm_off, hm_cnt;
        logic [DW-1:0] hm_wd, hm_rd, rd_d;

        idle_in();
        rst = 1'b1;
        exp_hr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack",  DW'(bus.hostAck),  '0);
        chk("reset_busy", DW'(bus.hostBusy), '0);
        chk("reset_rdata", bus.hostRData, '0);
        for (int s = 0; s < NS; s++) chk($sformatf("reset_readDatas%0d", s), bus.readDatas[s], '0);
        rst = 1'b0;

        // Give every word a known value so reads never see uninitialised storage.
        for (int s = 0; s < NS; s++)
            for (int o = 0; o < 256; o++) begin
                cpu_wr(s, o, DW'(s * 100000 + o * 7 + 3));
                tick();
            end
        idle_in();

        vt[0] = '{2, 'h10, 36'h123456789, 36'h123456789};
        vt[1] = '{0, 'h00, 36'hFFFFFFFFF, 36'hFFFFFFFFF};
        vt[2] = '{3, 'hFF, 36'h800000001, 36'h800000001};
        vt[3] = '{1, 'h80, 36'h000000000, 36'h000000000};
        vt[4] = '{3, 'h00, 36'h5A5A5A5A5, 36'h5A5A5A5A5};
        vt[5] = '{0, 'hFF, 36'hA5A5A5A5A, 36'hA5A5A5A5A};
        for (int i = 0; i < 6; i++) begin
            int nb;
            nb = (vt[i].seg + 1) % NS;
            cpu_wr(vt[i].seg, vt[i].off, vt[i].data);
            tick();
            idle_in();
            bus.readAddresses[vt[i].seg] = OW'(vt[i].off);
            bus.readAddresses[nb]        = OW'(vt[i].off);
            tick();
            chk($sformatf("vec%0d_read", i), bus.readDatas[vt[i].seg], vt[i].exp);
            chk($sformatf("vec%0d_neighbour", i), bus.readDatas[nb], mm[nb][vt[i].off]);
        end
        idle_in();

        // Host write, unblocked: ack two cycles after request, then visible to CPU.
        host_req(1'b1, 3, 'h05, 36'hABC);
        tick();
        idle_in();
        chk("hw_c1_ack", DW'(bus.hostAck), '0);
        chk("hw_c1_busy", DW'(bus.hostBusy), 36'd1);
        tick();
        chk("hw_c2_ack", DW'(bus.hostAck), 36'd1);
        mm[3]['h05] = 36'hABC;
        bus.readAddresses[3] = 8'h05;
        tick();
        chk("hw_c3_ack", DW'(bus.hostAck), '0);
        chk("hw_c3_busy", DW'(bus.hostBusy), '0);
        chk("hw_cpu_read", bus.readDatas[3], 36'hABC);
        idle_in();

        // Host read blocked five cycles by CPU writes to the same segment.
        host_req(1'b0, 1, 'h10, '0);
        tick();
        idle_in();
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("hr_stall_ack_c%0d", k), DW'(bus.hostAck), DW'(k == 8));
            chk($sformatf("hr_stall_busy_c%0d", k), DW'(bus.hostBusy), DW'(k <= 8));
            if (k == 8) begin
                exp_hr = mm[1]['h10];
                chk("hr_stall_rdata", bus.hostRData, exp_hr);
            end
            if (k <= 5) cpu_wr(1, 'h10, DW'(36'h5A5A0 + k));
            else        bus.writeEnables = '0;
            tick();
        end
        chk("hr_stall_rdata_held", bus.hostRData, 36'h5A5A5);

        // Host read of segment 0 while segment 3 is written every cycle: no stall.
        host_req(1'b0, 0, 'h40, '0);
        cpu_wr(3, 'h40, 36'h111);
        tick();
        bus.hostReq = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("hr_nostall_ack_c%0d", k), DW'(bus.hostAck), DW'(k == 3));
            if (k == 3) begin
                exp_hr = mm[0]['h40];
                chk("hr_nostall_rdata", bus.hostRData, exp_hr);
            end
            cpu_wr(3, 'h40, DW'(36'h111 + k));
            tick();
        end
        idle_in();

        // Same-cycle write and read of one address returns the old word.
        cpu_wr(0, 'h20, 36'h1);
        tick();
        cpu_wr(0, 'h20, 36'h5);
        bus.readAddresses[0] = 8'h20;
        tick();
        chk("rbw_old", bus.readDatas[0], 36'h1);
        bus.writeEnables = '0;
        tick();
        chk("rbw_new", bus.readDatas[0], 36'h5);
        idle_in();
        tick();

        // Randomized traffic against the reference model.
        rd_valid = 0;
        exp_ack  = 1'b0;
        exp_busy = 1'b0;
        hm_wait  = 0;
        hm_cnt   = 0;
        hm_we    = 0;
        hm_seg   = 0;
        hm_off   = 0;
        hm_wd    = '0;
        hm_rd    = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            if (rd_valid)
                for (int s = 0; s < NS; s++)
                    chk($sformatf("rnd_rd%0d_c%0d", s, cyc), bus.readDatas[s], exp_rd[s]);
            chk($sformatf("rnd_ack_c%0d", cyc),   DW'(bus.hostAck),  DW'(exp_ack));
            chk($sformatf("rnd_busy_c%0d", cyc),  DW'(bus.hostBusy), DW'(exp_busy));
            chk($sformatf("rnd_rdata_c%0d", cyc), bus.hostRData, exp_hr);

            for (int s = 0; s < NS; s++) bus.readAddresses[s] = OW'($urandom_range(0, 255));
            bus.writeAddress = OW'($urandom_range(0, 255));
            bus.writeData    = {4'($urandom), 32'($urandom)};
            r = $urandom_range(0, 9);
            if (hm_wait && r < 3) bus.writeEnables = NS'(1 << hm_seg);
            else if (r < 6)       bus.writeEnables = '0;
            else                  bus.writeEnables = NS'(1 << $urandom_range(0, NS - 1));
            bus.hostReq   = ($urandom_range(0, 3) == 0);
            bus.hostWe    = 1'($urandom);
            bus.hostAddr  = DAW'($urandom);
            bus.hostWData = {4'($urandom), 32'($urandom)};

            for (int s = 0; s < NS; s++) exp_rd[s] = mm[s][bus.readAddresses[s]];
            rd_valid = 1;
            exp_ack  = 1'b0;
            if (hm_cnt > 0) begin
                hm_cnt--;
                if (hm_cnt == 0) begin
                    exp_ack = 1'b1;
                    exp_hr  = hm_rd;
                end
            end else if (hm_wait && !bus.writeEnables[hm_seg]) begin
                hm_wait = 0;
                if (hm_we) begin
                    mm[hm_seg][hm_off] = hm_wd;
                    exp_ack = 1'b1;
                end else begin
                    hm_rd  = mm[hm_seg][hm_off];
                    hm_cnt = 1;
                end
            end
            for (int s = 0; s < NS; s++)
                if (bus.writeEnables[s]) mm[s][bus.writeAddress] = bus.writeData;
            if (!exp_busy && bus.hostReq) begin
                hm_wait = 1;
                hm_we   = bus.hostWe;
                hm_seg  = int'(bus.hostAddr) / 256;
                hm_off  = int'(bus.hostAddr) % 256;
                hm_wd   = bus.hostWData;
            end
            exp_busy = hm_wait || (hm_cnt > 0) || exp_ack;
            tick();
        end
        idle_in();
        for (int k = 0; k < 4; k++) tick();

        // Reset while a host write is stuck in PEND abandons it.
        rd_d = mm[2]['h33];
        host_req(1'b1, 2, 'h33, 36'hDEAD);
        cpu_wr(2, 'h34, 36'h777);
        tick();
        bus.hostReq = 1'b0;
        chk("rstpend_busy_c1", DW'(bus.hostBusy), 36'd1);
        tick();
        chk("rstpend_busy_c2", DW'(bus.hostBusy), 36'd1);
        rst = 1'b1;
        #1;
        chk("rstpend_busy", DW'(bus.hostBusy), '0);
        chk("rstpend_ack",  DW'(bus.hostAck),  '0);
        chk("rstpend_rdata", bus.hostRData, '0);
        chk("rstpend_readDatas2", bus.readDatas[2], '0);
        exp_hr = '0;
        idle_in();
        tick();
        rst = 1'b0;
        host_req(1'b0, 2, 'h33, '0);
        bus.readAddresses[2] = 8'h33;
        tick();
        bus.hostReq = 1'b0;
        chk("rstpend_word_kept", bus.readDatas[2], rd_d);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("rstpend_rd_ack_c%0d", k), DW'(bus.hostAck), DW'(k == 3));
            if (k == 3) chk("rstpend_rd_data", bus.hostRData, rd_d);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
